imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter MAX_WORDS, default 256, is the instruction BRAM capacity in 32-bit words (10-bit byte address).
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  single-cycle request to begin or restart a program load.
REQ-005 s_valid  input  1  byte-stream data valid.
REQ-006 s_data  input  8  byte-stream payload.
REQ-007 s_ready  output  1  loader can accept a byte; a byte transfers when s_valid && s_ready on a clock edge.
REQ-008 i_w_addr  output  10  instruction BRAM write byte address, word-aligned.
REQ-009 i_w_dat  output  32  instruction BRAM write data.
REQ-010 i_w_enb  output  1  instruction BRAM write enable.
REQ-011 pc_stall  output  1  holds the CPU program counter; drives the pc stall input.
REQ-012 load_done  output  1  program loaded and checksum verified.
REQ-013 load_error  output  1  load aborted: bad length or bad checksum.

Function
REQ-014 States: IDLE, HDR0, HDR1, DATA, WRITE, CSUM, DONE, ERROR.
REQ-015 IDLE: start moves to HDR0; no other input has any effect.
REQ-016 s_ready is 1 only in HDR0, HDR1, DATA and CSUM, and is 0 in every other state.
REQ-017 HDR0 takes the low byte and HDR1 the high byte of the 16-bit word count N (little-endian); each advances only on an accepted byte.
REQ-018 After HDR1: N=0 or N>MAX_WORDS goes to ERROR; otherwise go to DATA with word index 0 and checksum 0x00.
REQ-019 DATA assembles 4 accepted bytes little-endian (first byte = bits 7:0); each byte is XORed into the 8-bit checksum.
REQ-020 On the 4th accepted byte, go to WRITE; in WRITE, i_w_enb=1 for exactly one cycle, with i_w_addr=index*4 and i_w_dat=assembled word.
REQ-021 After WRITE, increment the index: if the index now equals N, go to CSUM, otherwise return to DATA.
REQ-022 CSUM: the accepted byte equal to the running checksum goes to DONE; any other value goes to ERROR.
REQ-023 DONE: pc_stall=0, load_done=1.
REQ-024 ERROR: load_error=1, pc_stall=1.
REQ-025 In DONE or ERROR, start clears load_done and load_error, sets pc_stall=1 in the next cycle, and goes to HDR0.
REQ-026 start is ignored in HDR0 through CSUM.
REQ-027 Gaps in s_valid at any point stall progress with no side effects; there is no timeout.
REQ-028 pc_stall=1 in every state except DONE.
REQ-029 i_w_addr never wraps: the highest address written is (MAX_WORDS-1)*4 = 0x3FC.

Reset
REQ-030 Asserting rst sets, asynchronously: state IDLE, s_ready=0, i_w_enb=0, i_w_addr=0, i_w_dat=0, pc_stall=1, load_done=0, load_error=0, index=0, checksum=0.
REQ-031 Reset during a load abandons it; BRAM words already written are not cleared; a new start is required.

Structure
REQ-032 State encodings and the header/checksum format constants live in a shared include alongside rv32i_params.vh; DATA_WIDTH comes from rv32i_params.vh.
REQ-033 One sub-module is natural: word_assembler (byte shift register plus byte counter, asserts word_ready on the 4th byte); everything else is in the FSM.

Verification
REQ-034 Load: start; bytes 02 00 93 02 50 00 13 03 30 00 E1 -> write addr 0x000 dat 00500293, then addr 0x004 dat 00300313; load_done=1; pc_stall=0.
REQ-035 Bad checksum: same stream with last byte E0 -> both writes occur; load_error=1; pc_stall stays 1; load_done=0.
REQ-036 Length errors: header 00 00 -> ERROR right after HDR1 with no writes; header 01 01 (257) -> ERROR with no writes.
REQ-037 Backpressure: stream from REQ-034 with s_valid asserted every third cycle -> identical write sequence; each i_w_enb pulse is 1 cycle wide.
REQ-038 Reset mid-load: rst after 5 bytes -> all outputs at reset values at once, no further i_w_enb; then start plus the REQ-034 stream -> load_done=1.
REQ-039 Capacity: N=256 -> last write at addr 0x3FC; load_done=1 after the correct checksum; then start -> pc_stall=1, load_done=0, state HDR0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and format constants for the instruction-memory loader.
// Stream format: 16-bit little-endian word count, N little-endian words, XOR checksum byte.
package imem_loader_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int BYTE_W     = 8;
   localparam int ADDR_W     = 10;
   localparam int LEN_W      = 16;

   localparam logic [BYTE_W-1:0] CSUM_INIT = 8'h00;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR0,
      S_HDR1,
      S_DATA,
      S_WRITE,
      S_CSUM,
      S_DONE,
      S_ERROR
   } state_t;

   // A program must hold at least one word and fit in the instruction BRAM.
   function automatic logic len_ok(input logic [LEN_W-1:0] n, input int unsigned max_words);
      return (n != '0) && (32'(n) <= max_words);
   endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Collects four bytes little-endian into a 32-bit word; word_ready marks the 4th byte,
// with word already presenting the complete value in that same cycle.
module imem_loader_word_assembler
   import imem_loader_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  byte_valid,
   input  logic [BYTE_W-1:0]     byte_data,
   output logic [DATA_WIDTH-1:0] word,
   output logic                  word_ready
);

   logic [DATA_WIDTH-BYTE_W-1:0] shreg;
   logic [1:0]                   cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg <= '0;
         cnt   <= '0;
      end else if (clear) begin
         cnt   <= '0;
      end else if (byte_valid) begin
         shreg <= {byte_data, shreg[DATA_WIDTH-BYTE_W-1:BYTE_W]};
         cnt   <= cnt + 2'd1;
      end
   end

   // The oldest byte ends up in bits 7:0 once the fourth byte is shifted in.
   assign word       = {byte_data, shreg};
   assign word_ready = byte_valid && (cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Loads a program from a byte stream into instruction BRAM, holding the CPU in stall
// until the whole image has been written and its XOR checksum matches.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int MAX_WORDS = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  s_valid,
   input  logic [BYTE_W-1:0]     s_data,
   output logic                  s_ready,
   output logic [ADDR_W-1:0]     i_w_addr,
   output logic [DATA_WIDTH-1:0] i_w_dat,
   output logic                  i_w_enb,
   output logic                  pc_stall,
   output logic                  load_done,
   output logic                  load_error
);

   state_t                  state, state_nx;
   logic [LEN_W-1:0]        n_words;
   logic [LEN_W-1:0]        index;
   logic [LEN_W-1:0]        index_inc;
   logic [BYTE_W-1:0]       csum;
   logic                    hdr1_acc;
   logic                    data_acc;
   logic                    word_ready;
   logic [DATA_WIDTH-1:0]   word;

   assign s_ready   = (state == S_HDR0) || (state == S_HDR1) ||
                      (state == S_DATA) || (state == S_CSUM);
   assign hdr1_acc  = (state == S_HDR1) && s_valid;
   assign data_acc  = (state == S_DATA) && s_valid;
   assign index_inc = index + LEN_W'(1);

   imem_loader_word_assembler u_asm (
      .clk        (clk),
      .rst        (rst),
      .clear      (hdr1_acc),
      .byte_valid (data_acc),
      .byte_data  (s_data),
      .word       (word),
      .word_ready (word_ready)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      i_w_enb    = 1'b0;
      pc_stall   = 1'b1;
      load_done  = 1'b0;
      load_error = 1'b0;
      case (state)
         S_IDLE:  if (start) state_nx = S_HDR0;
         S_HDR0:  if (s_valid) state_nx = S_HDR1;
         S_HDR1:  if (s_valid)
                     state_nx = len_ok({s_data, n_words[BYTE_W-1:0]}, MAX_WORDS) ? S_DATA : S_ERROR;
         S_DATA:  if (word_ready) state_nx = S_WRITE;
         S_WRITE: begin
            i_w_enb  = 1'b1;
            state_nx = (index_inc == n_words) ? S_CSUM : S_DATA;
         end
         S_CSUM:  if (s_valid) state_nx = (s_data == csum) ? S_DONE : S_ERROR;
         S_DONE: begin
            pc_stall  = 1'b0;
            load_done = 1'b1;
            if (start) state_nx = S_HDR0;
         end
         S_ERROR: begin
            load_error = 1'b1;
            if (start) state_nx = S_HDR0;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Header capture, checksum accumulation and the BRAM write port registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         n_words  <= '0;
         index    <= '0;
         csum     <= CSUM_INIT;
         i_w_addr <= '0;
         i_w_dat  <= '0;
      end else begin
         case (state)
            S_HDR0: if (s_valid) n_words[BYTE_W-1:0] <= s_data;
            S_HDR1: if (s_valid) begin
               n_words[LEN_W-1:BYTE_W] <= s_data;
               index <= '0;
               csum  <= CSUM_INIT;
            end
            S_DATA: if (s_valid) begin
               csum <= csum ^ s_data;
               if (word_ready) begin
                  i_w_addr <= {index[ADDR_W-3:0], 2'b00};
                  i_w_dat  <= word;
               end
            end
            S_WRITE: index <= index_inc;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: fixed vector table, hand-built corner sequences and
// randomized loads checked against a whole-stream reference model.
module tb_imem_loader;

   localparam int MAXW = 256;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        s_valid;
   logic [7:0]  s_data;
   logic        s_ready;
   logic [9:0]  i_w_addr;
   logic [31:0] i_w_dat;
   logic        i_w_enb;
   logic        pc_stall;
   logic        load_done;
   logic        load_error;

   always #5 clk = ~clk;

   imem_loader #(.MAX_WORDS(MAXW)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .s_valid    (s_valid),
      .s_data     (s_data),
      .s_ready    (s_ready),
      .i_w_addr   (i_w_addr),
      .i_w_dat    (i_w_dat),
      .i_w_enb    (i_w_enb),
      .pc_stall   (pc_stall),
      .load_done  (load_done),
      .load_error (load_error)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   logic [9:0]  cap_addr[$];
   logic [31:0] cap_dat[$];
   logic        prev_enb = 1'b0;
   int          wide_pulses = 0;

   always @(negedge clk) begin
      if (i_w_enb) begin
         cap_addr.push_back(i_w_addr);
         cap_dat.push_back(i_w_dat);
      end
      if (i_w_enb && prev_enb) wide_pulses++;
      prev_enb = i_w_enb;
   end

   logic [7:0]  stim[$];
   logic [9:0]  exp_addr[$];
   logic [31:0] exp_dat[$];
   logic        exp_done;
   logic        exp_err;

   typedef struct {
      logic [87:0] bytes;
      int          nb;
      int          gap;
      logic        done;
      logic        err;
      int          nw;
      logic [31:0] d0;
      logic [31:0] d1;
   } vec_t;

   vec_t tbl[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Reference: interpret the whole stream from the format rules.
   task automatic ref_model();
      int          n;
      logic [7:0]  x;
      logic [31:0] w;
      exp_addr.delete();
      exp_dat.delete();
      n = int'({stim[1], stim[0]});
      if (n == 0 || n > MAXW) begin
         exp_done = 1'b0;
         exp_err  = 1'b1;
         return;
      end
      x = 8'h00;
      for (int i = 0; i < n; i++) begin
         w = 32'h0;
         for (int b = 0; b < 4; b++) begin
            w = w | (32'(stim[2 + 4*i + b]) << (8*b));
            x = x ^ stim[2 + 4*i + b];
         end
         exp_addr.push_back(10'(4*i));
         exp_dat.push_back(w);
      end
      exp_done = (stim[2 + 4*n] == x);
      exp_err  = !exp_done;
   endtask

   // Called at a falling edge; returns at the falling edge after the transfer.
   task automatic send_byte(input logic [7:0] b);
      int waited = 0;
      s_valid = 1'b1;
      s_data  = b;
      while (!s_ready && waited < 64) begin
         @(negedge clk);
         waited++;
      end
      if (!s_ready) begin
         n_cmp++;
         n_fail++;
         $display("FAIL s_ready_timeout: byte 0x%0h never accepted", b);
      end
      @(negedge clk);
      s_valid = 1'b0;
      s_data  = 8'($urandom);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // gap_mode 0: back-to-back, 1: valid every third cycle, 2: random gaps with stray starts
   task automatic drive_stream(input int gap_mode);
      int g;
      cap_addr.delete();
      cap_dat.delete();
      pulse_start();
      for (int i = 0; i < stim.size(); i++) begin
         send_byte(stim[i]);
         if (i != stim.size() - 1) begin
            g = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 2 : int'($urandom_range(0, 3));
            for (int k = 0; k < g; k++) begin
               start = (gap_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
               @(negedge clk);
            end
            start = 1'b0;
         end
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic check_model(input string tag);
      int m;
      check($sformatf("%s_nwrites", tag), 32'(cap_addr.size()), 32'(exp_addr.size()));
      m = (cap_addr.size() < exp_addr.size()) ? cap_addr.size() : exp_addr.size();
      for (int i = 0; i < m; i++) begin
         check($sformatf("%s_addr%0d", tag, i), 32'(cap_addr[i]), 32'(exp_addr[i]));
         check($sformatf("%s_dat%0d", tag, i), cap_dat[i], exp_dat[i]);
      end
      check($sformatf("%s_done", tag), 32'(load_done), 32'(exp_done));
      check($sformatf("%s_err", tag), 32'(load_error), 32'(exp_err));
      check($sformatf("%s_stall", tag), 32'(pc_stall), 32'(!exp_done));
   endtask

   task automatic check_reset_outputs(input string tag);
      check($sformatf("%s_s_ready", tag), 32'(s_ready), 32'd0);
      check($sformatf("%s_enb", tag), 32'(i_w_enb), 32'd0);
      check($sformatf("%s_addr", tag), 32'(i_w_addr), 32'd0);
      check($sformatf("%s_dat", tag), i_w_dat, 32'd0);
      check($sformatf("%s_stall", tag), 32'(pc_stall), 32'd1);
      check($sformatf("%s_done", tag), 32'(load_done), 32'd0);
      check($sformatf("%s_err", tag), 32'(load_error), 32'd0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] n;
      int          kind;
      logic [7:0]  x;
      logic [7:0]  b;

      tbl[0] = '{88'hE1_00_30_03_13_00_50_02_93_00_02, 11, 0, 1'b1, 1'b0, 2, 32'h00500293, 32'h00300313};
      tbl[1] = '{88'hE0_00_30_03_13_00_50_02_93_00_02, 11, 0, 1'b0, 1'b1, 2, 32'h00500293, 32'h00300313};
      tbl[2] = '{88'h0000,                              2, 0, 1'b0, 1'b1, 0, 32'h0,        32'h0};
      tbl[3] = '{88'h0101,                              2, 0, 1'b0, 1'b1, 0, 32'h0,        32'h0};
      tbl[4] = '{88'hE1_00_30_03_13_00_50_02_93_00_02, 11, 1, 1'b1, 1'b0, 2, 32'h00500293, 32'h00300313};

      rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      // IDLE ignores stream traffic until start
      s_valid = 1'b1; s_data = 8'h02;
      repeat (3) @(negedge clk);
      check("idle_s_ready", 32'(s_ready), 32'd0);
      check("idle_stall", 32'(pc_stall), 32'd1);
      check("idle_nwrites", 32'(cap_addr.size()), 32'd0);
      s_valid = 1'b0;

      for (int t = 0; t < 5; t++) begin
         stim.delete();
         for (int k = 0; k < tbl[t].nb; k++) stim.push_back(tbl[t].bytes[8*k +: 8]);
         wide_pulses = 0;
         drive_stream(tbl[t].gap);
         check($sformatf("tbl%0d_nwrites", t), 32'(cap_addr.size()), 32'(tbl[t].nw));
         if (cap_addr.size() >= 1 && tbl[t].nw >= 1) begin
            check($sformatf("tbl%0d_addr0", t), 32'(cap_addr[0]), 32'h000);
            check($sformatf("tbl%0d_dat0", t), cap_dat[0], tbl[t].d0);
         end
         if (cap_addr.size() >= 2 && tbl[t].nw >= 2) begin
            check($sformatf("tbl%0d_addr1", t), 32'(cap_addr[1]), 32'h004);
            check($sformatf("tbl%0d_dat1", t), cap_dat[1], tbl[t].d1);
         end
         check($sformatf("tbl%0d_done", t), 32'(load_done), 32'(tbl[t].done));
         check($sformatf("tbl%0d_err", t), 32'(load_error), 32'(tbl[t].err));
         check($sformatf("tbl%0d_stall", t), 32'(pc_stall), 32'(!tbl[t].done));
         check($sformatf("tbl%0d_wide_pulses", t), 32'(wide_pulses), 32'd0);
      end

      // Reset in the middle of a load
      stim.delete();
      for (int k = 0; k < 11; k++) stim.push_back(tbl[0].bytes[8*k +: 8]);
      pulse_start();
      for (int k = 0; k < 5; k++) send_byte(stim[k]);
      rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      cap_addr.delete();
      cap_dat.delete();
      repeat (3) @(negedge clk);
      check("midrst_nwrites", 32'(cap_addr.size()), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      ref_model();
      drive_stream(0);
      check_model("after_rst");

      // Full-capacity image
      stim.delete();
      stim.push_back(8'h00);
      stim.push_back(8'h01);
      x = 8'h00;
      for (int k = 0; k < 4*MAXW; k++) begin
         b = 8'($urandom);
         x = x ^ b;
         stim.push_back(b);
      end
      stim.push_back(x);
      ref_model();
      drive_stream(0);
      check_model("cap");
      check("cap_last_addr", 32'(cap_addr.size() > 0 ? cap_addr[cap_addr.size()-1] : 10'h0), 32'h3FC);
      pulse_start();
      check("restart_stall", 32'(pc_stall), 32'd1);
      check("restart_done", 32'(load_done), 32'd0);
      check("restart_s_ready", 32'(s_ready), 32'd1);
      send_byte(8'h00);
      send_byte(8'h00);
      @(negedge clk);
      check("restart_len0_err", 32'(load_error), 32'd1);

      // Randomized loads
      for (int r = 0; r < 14; r++) begin
         kind = int'($urandom_range(0, 9));
         if (kind == 0)      n = 16'd0;
         else if (kind == 1) n = 16'(257 + $urandom_range(0, 1000));
         else                n = 16'($urandom_range(1, 8));
         stim.delete();
         stim.push_back(n[7:0]);
         stim.push_back(n[15:8]);
         if (kind >= 2) begin
            x = 8'h00;
            for (int k = 0; k < 4*int'(n); k++) begin
               b = 8'($urandom);
               x = x ^ b;
               stim.push_back(b);
            end
            if ($urandom_range(0, 9) < 3) x = x ^ 8'(1 << $urandom_range(0, 7));
            stim.push_back(x);
         end
         ref_model();
         drive_stream(2);
         check_model($sformatf("rnd%0d", r));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
